// File: rtl/mul_pkg.sv
// Shared constants, FSM encoding and flag helper for the 64-bit shift-add multiplier.
package mul_pkg;

  localparam int WIDTH      = 64;
  localparam int ITERATIONS = 64;
  localparam int COUNT_W    = 7;

  localparam logic [COUNT_W-1:0] LAST_COUNT = 7'd63;
  localparam logic [COUNT_W-1:0] COUNT_ONE  = 7'd1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

  function automatic logic is_zero(input logic [WIDTH-1:0] v);
    return (v == {WIDTH{1'b0}});
  endfunction

endpackage

// File: rtl/adder_64bit.sv
// 64-bit ripple-free behavioural adder with carry-out and signed overflow flags.
module adder_64bit
  import mul_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  logic [WIDTH:0] full_s;

  // Full-width sum; overflow when like-signed operands give an unlike-signed result.
  always_comb begin
    full_s    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    sum       = full_s[WIDTH-1:0];
    carry_out = full_s[WIDTH];
    overflow  = (a[WIDTH-1] == b[WIDTH-1]) && (full_s[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/seq_multiplier_64bit.sv
// Sequential shift-add multiplier: 64 iterations per operation, low 64 product bits,
// registered product/zero/negative flags that hold until the next accepted start.
module seq_multiplier_64bit
  import mul_pkg::*;
#(
  parameter int WIDTH = mul_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             zero,
  output logic             negative
);

  if (WIDTH != 64) begin : g_width_check
    $error("seq_multiplier_64bit supports WIDTH = 64 only");
  end

  state_e             state_r;
  state_e             state_next_s;
  logic [WIDTH-1:0]   acc_r;
  logic [WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [COUNT_W-1:0] count_r;
  logic [WIDTH-1:0]   product_r;
  logic               busy_r;
  logic               done_r;
  logic               zero_r;
  logic               negative_r;

  logic [WIDTH-1:0]   add_sum_s;
  logic [WIDTH-1:0]   acc_next_s;
  logic               accept_s;
  logic               last_s;
  logic               unused_cout_s;
  logic               unused_ovf_s;

  adder_64bit u_adder (
    .a         (acc_r),
    .b         (mcand_r),
    .cin       (1'b0),
    .sum       (add_sum_s),
    .carry_out (unused_cout_s),
    .overflow  (unused_ovf_s)
  );

  // Start acceptance, final-iteration detect and conditional accumulate.
  always_comb begin
    accept_s   = start && ((state_r == IDLE) || (state_r == DONE));
    last_s     = (state_r == RUN) && (count_r == LAST_COUNT);
    acc_next_s = acc_r;
    if (mplier_r[0]) begin
      acc_next_s = add_sum_s;
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Next-state logic; start is only honoured outside RUN.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = RUN;
        else       state_next_s = IDLE;
      end
      RUN: begin
        if (last_s) state_next_s = DONE;
        else        state_next_s = RUN;
      end
      DONE: begin
        if (start) state_next_s = RUN;
        else       state_next_s = IDLE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath: operands latched on acceptance, one shift-add step per RUN cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r    <= {WIDTH{1'b0}};
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      count_r  <= {COUNT_W{1'b0}};
    end else if (accept_s) begin
      acc_r    <= {WIDTH{1'b0}};
      mcand_r  <= A;
      mplier_r <= B;
      count_r  <= {COUNT_W{1'b0}};
    end else if (state_r == RUN) begin
      acc_r    <= acc_next_s;
      mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
      count_r  <= count_r + COUNT_ONE;
    end else begin
      acc_r    <= acc_r;
      mcand_r  <= mcand_r;
      mplier_r <= mplier_r;
      count_r  <= count_r;
    end
  end

  // Registered status and result; the final accumulate is captured on the RUN->DONE edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      product_r  <= {WIDTH{1'b0}};
      zero_r     <= 1'b1;
      negative_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s == RUN);
      done_r <= (state_next_s == DONE);
      if (accept_s) begin
        product_r  <= {WIDTH{1'b0}};
        zero_r     <= 1'b1;
        negative_r <= 1'b0;
      end else if (last_s) begin
        product_r  <= acc_next_s;
        zero_r     <= is_zero(acc_next_s);
        negative_r <= acc_next_s[WIDTH-1];
      end else begin
        product_r  <= product_r;
        zero_r     <= zero_r;
        negative_r <= negative_r;
      end
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign product  = product_r;
  assign zero     = zero_r;
  assign negative = negative_r;

endmodule

// File: tb/tb_seq_multiplier_64bit.sv
// Directed bench for seq_multiplier_64bit with hand-computed products and latency checks.
module tb_seq_multiplier_64bit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [63:0] A;
  logic [63:0] B;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic        zero;
  logic        negative;

  int compared;
  int mismatched;

  seq_multiplier_64bit dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .zero     (zero),
    .negative (negative)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: present operands and raise start for the next rising edge.
  task automatic start_op(input logic [63:0] a, input logic [63:0] b);
    A     = a;
    B     = b;
    start = 1'b1;
  endtask

  // Follows an accepted operation to its done pulse and checks timing and result.
  task automatic wait_done(input string tag, input logic [63:0] exp_p,
                           input logic exp_z, input logic exp_n, input int inject_at);
    int n;
    int busy_n;
    int both_n;
    n = 0;
    busy_n = 0;
    both_n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        start = 1'b0;
        chk({tag, "_clr_prod"}, product, 64'd0);
        chk({tag, "_clr_zero"}, {63'd0, zero}, 64'd1);
      end
      if (busy) busy_n++;
      if (busy && done) both_n++;
      if (inject_at != 0 && n == inject_at) begin
        start = 1'b1;
        A     = 64'd100;
        B     = 64'd100;
      end else if (inject_at != 0 && n == inject_at + 1) begin
        start = 1'b0;
      end
    end while (!done && n < 200);
    chk({tag, "_latency"}, 64'(n), 64'd65);
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'd64);
    chk({tag, "_busy_done_overlap"}, 64'(both_n), 64'd0);
    chk({tag, "_product"}, product, exp_p);
    chk({tag, "_zero"}, {63'd0, zero}, {63'd0, exp_z});
    chk({tag, "_negative"}, {63'd0, negative}, {63'd0, exp_n});
  endtask

  // Called at the done negedge: result must hold while idle.
  task automatic check_hold(input string tag, input logic [63:0] exp_p);
    repeat (3) @(negedge clk);
    chk({tag, "_hold_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_hold_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_hold_product"}, product, exp_p);
  endtask

  initial begin
    int done_seen;
    compared   = 0;
    mismatched = 0;
    reset = 1'b1;
    start = 1'b0;
    A     = 64'd0;
    B     = 64'd0;

    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_product", product, 64'd0);
    chk("rst_zero", {63'd0, zero}, 64'd1);
    chk("rst_negative", {63'd0, negative}, 64'd0);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", {63'd0, busy}, 64'd0);

    start_op(64'd3, 64'd5);
    wait_done("mul3x5", 64'd15, 1'b0, 1'b0, 0);
    check_hold("mul3x5", 64'd15);

    start_op(64'hFFFF_FFFF_FFFF_FFFE, 64'd3);
    wait_done("neg2x3", 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 1'b1, 0);

    start_op(64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000);
    wait_done("wrap", 64'd0, 1'b1, 1'b0, 0);

    start_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd6);
    wait_done("neg7x6", 64'hFFFF_FFFF_FFFF_FFD6, 1'b0, 1'b1, 0);

    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_done("allones", 64'd1, 1'b0, 1'b0, 0);

    start_op(64'd7, 64'd6);
    wait_done("ignore_start", 64'd42, 1'b0, 1'b0, 10);
    check_hold("ignore_start", 64'd42);

    start_op(64'd9, 64'd9);
    repeat (30) @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_product", product, 64'd0);
    chk("midrst_zero", {63'd0, zero}, 64'd1);
    done_seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (i == 2) reset = 1'b0;
      if (done || busy) done_seen++;
    end
    chk("midrst_no_done", 64'(done_seen), 64'd0);

    start_op(64'd9, 64'd9);
    wait_done("restart9x9", 64'd81, 1'b0, 1'b0, 0);

    start_op(64'd4, 64'd4);
    wait_done("done_start", 64'd16, 1'b0, 1'b0, 0);
    check_hold("done_start", 64'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
